sprite_draw_scheduler: RTL and testbench
========================================

// Module: sprite_draw_scheduler
// PURPOSE
//   Shares the single VGA framebuffer write port between the three movers
//   (cannon, alien block, cannon shot). Arbitrates redraw requests round-robin,
//   then for the winner erases its previously drawn rectangle and draws it at
//   the new position, one pixel per clock. It sits between the movers and the
//   VGA adapter and is the only block that drives the adapter plot port.
// PARAMETERS
//   CANNON_W    13      cannon sprite width, pixels (1..16)
//   CANNON_H    4       cannon sprite height, pixels (1..16)
//   ALIEN_W     8       alien block width, pixels (1..16)
//   ALIEN_H     6       alien block height, pixels (1..16)
//   SHOT_W      1       shot width, pixels (1..16)
//   SHOT_H      3       shot height, pixels (1..16)
//   COL_CANNON  3'b010  cannon colour
//   COL_ALIEN   3'b111  alien colour
//   COL_SHOT    3'b110  shot colour
//   COL_BG      3'b000  background colour used for erase
// PORTS
//   clock     in   1  system clock
//   reset     in   1  synchronous, active-low
//   req       in   3  redraw request, level; [0]=cannon [1]=aliens [2]=shot
//   x0,y0     in   8  cannon top-left position
//   x1,y1     in   8  alien block top-left position
//   x2,y2     in   8  shot top-left position
//   vga_x     out  8  pixel x to adapter
//   vga_y     out  7  pixel y to adapter
//   colour    out  3  pixel colour
//   plot      out  1  write enable, one pixel per cycle when high
//   busy      out  1  high whenever state != IDLE
//   done      out  3  one-hot, one-cycle pulse when a requester's redraw ends
// BEHAVIOUR
//   - All outputs registered; on reset: vga_x=0, vga_y=0, colour=0, plot=0,
//     busy=0, done=0, state=IDLE, rr pointer=2 (so 0 wins first), all
//     old-valid flags cleared. Reset mid-operation aborts the scan at once.
//   - States: IDLE, ERASE, DRAW, DONE.
//   - IDLE: if req!=0, winner = first asserted index after rr pointer (mod 3);
//     latch winner's x,y into new_x,new_y, W/H/colour from its params; reset
//     cx=cy=0; go ERASE if old_valid[winner] else DRAW. No request: stay.
//   - ERASE: each cycle emit pixel (old_x+cx, old_y+cy), colour=COL_BG.
//     cx increments 0..W-1, then cx=0 and cy++; after (W-1,H-1) go DRAW with
//     cx=cy=0. Exactly W*H cycles.
//   - DRAW: same scan over (new_x+cx, new_y+cy) with sprite colour; after last
//     pixel go DONE. Exactly W*H cycles.
//   - DONE (1 cycle): done[winner]=1, old_x/old_y[winner]<=new_x/new_y,
//     old_valid[winner]<=1, rr pointer<=winner, then IDLE.
//   - Latency req->first plot: 2 cycles (IDLE decision, first pixel register).
//     Full job = 1 + (erase ? W*H : 0) + W*H + 1 cycles.
//   - Coordinates sampled only in IDLE; later changes to x/y are ignored for
//     the running job. req dropped mid-job: job still completes, done pulses.
//   - Clipping: sums computed 9-bit; pixel with x>=160 or y>=120 gets plot=0
//     but still consumes its cycle. vga_y = low 7 bits of y sum.
//   - plot=0 in IDLE and DONE; busy=1 in ERASE/DRAW/DONE.
//   - A requester still asserting req after DONE competes again in IDLE;
//     rr pointer guarantees no requester is served twice while another waits.
// TESTING
//   - Post-reset req=001, x0=16,y0=111: no erase, 52 plots colour 010 over
//     x16..28,y111..114; done=001 on cycle 54; busy low after.
//   - Then x0=17, req=001: 52 plots colour 000 at x16..28, then 52 colour 010
//     at x17..29; done=001 after 106 cycles.
//   - After reset req=111 held: service order 0,1,2,0,...; done pulses in
//     that order, never two bits set at once.
//   - Alien at x1=156,y1=16: columns cx=4..7 have plot=0, cx=0..3 plot=1;
//     total DRAW still 48 cycles.
//   - Reset low during DRAW of aliens: next cycle plot=0, busy=0; next alien
//     request draws without erase (old_valid cleared).
//   - x2 changed mid-job and req2 dropped after 1 cycle: drawn at latched
//     position, done=100 still pulses once.

Source files
------------

// File: rtl/sprite_draw_scheduler.sv
// Round-robin owner of the framebuffer plot port: erases each mover's previous
// rectangle and redraws it at its new position, one pixel per clock.
module sprite_draw_scheduler #(
   parameter int         CANNON_W   = 13,
   parameter int         CANNON_H   = 4,
   parameter int         ALIEN_W    = 8,
   parameter int         ALIEN_H    = 6,
   parameter int         SHOT_W     = 1,
   parameter int         SHOT_H     = 3,
   parameter logic [2:0] COL_CANNON = 3'b010,
   parameter logic [2:0] COL_ALIEN  = 3'b111,
   parameter logic [2:0] COL_SHOT   = 3'b110,
   parameter logic [2:0] COL_BG     = 3'b000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [2:0] req,
   input  logic [7:0] x0,
   input  logic [7:0] y0,
   input  logic [7:0] x1,
   input  logic [7:0] y1,
   input  logic [7:0] x2,
   input  logic [7:0] y2,
   output logic [7:0] vga_x,
   output logic [6:0] vga_y,
   output logic [2:0] colour,
   output logic       plot,
   output logic       busy,
   output logic [2:0] done
);

   typedef enum logic [1:0] {IDLE, ERASE, DRAW, DONE} state_t;

   state_t     state, state_next;
   logic [1:0] rr_ptr, winner, pick, idx;
   logic       found;
   logic [2:0] old_valid;
   logic [7:0] old_x [0:2];
   logic [7:0] old_y [0:2];
   logic [7:0] new_x, new_y;
   logic [3:0] w_m1, h_m1, cx, cy;
   logic [2:0] sprite_col;

   logic [7:0] pick_x, pick_y;
   logic [3:0] pick_w, pick_h;
   logic [2:0] pick_col;

   logic [7:0] base_x, base_y;
   logic [8:0] sum_x, sum_y;
   logic [2:0] px_col;
   logic       px_on, last_px, plot_next;

   // First asserted requester after the pointer, wrapping modulo 3.
   always_comb begin
      pick  = rr_ptr;
      found = 1'b0;
      idx   = 2'd0;
      for (int k = 1; k <= 3; k++) begin
         idx = 2'((int'(rr_ptr) + k) % 3);
         if (!found && req[idx]) begin
            pick  = idx;
            found = 1'b1;
         end
      end
   end

   always_comb begin
      case (pick)
         2'd0: begin
            pick_x = x0; pick_y = y0; pick_col = COL_CANNON;
            pick_w = 4'(CANNON_W - 1); pick_h = 4'(CANNON_H - 1);
         end
         2'd1: begin
            pick_x = x1; pick_y = y1; pick_col = COL_ALIEN;
            pick_w = 4'(ALIEN_W - 1); pick_h = 4'(ALIEN_H - 1);
         end
         default: begin
            pick_x = x2; pick_y = y2; pick_col = COL_SHOT;
            pick_w = 4'(SHOT_W - 1); pick_h = 4'(SHOT_H - 1);
         end
      endcase
   end

   assign last_px = (cx == w_m1) && (cy == h_m1);

   // NOTE: every signal gets a default first so no path leaves one unassigned (no latches).
   always_comb begin
      state_next = state;
      base_x     = 8'd0;
      base_y     = 8'd0;
      px_col     = COL_BG;
      px_on      = 1'b0;
      case (state)
         IDLE:  if (|req) state_next = old_valid[pick] ? ERASE : DRAW;
         ERASE: begin
            base_x = old_x[winner];
            base_y = old_y[winner];
            px_on  = 1'b1;
            if (last_px) state_next = DRAW;
         end
         DRAW: begin
            base_x = new_x;
            base_y = new_y;
            px_col = sprite_col;
            px_on  = 1'b1;
            if (last_px) state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
      sum_x     = {1'b0, base_x} + {5'd0, cx};
      sum_y     = {1'b0, base_y} + {5'd0, cy};
      plot_next = px_on && (sum_x < 9'd160) && (sum_y < 9'd120);
   end

   always_ff @(posedge clock) begin
      if (!reset) state <= IDLE;
      else        state <= state_next;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         vga_x     <= 8'd0;
         vga_y     <= 7'd0;
         colour    <= 3'd0;
         plot      <= 1'b0;
         busy      <= 1'b0;
         done      <= 3'd0;
         rr_ptr    <= 2'd2;
         winner    <= 2'd0;
         old_valid <= 3'd0;
         cx        <= 4'd0;
         cy        <= 4'd0;
      end else begin
         vga_x  <= sum_x[7:0];
         vga_y  <= sum_y[6:0];
         colour <= px_col;
         plot   <= plot_next;
         busy   <= (state_next != IDLE);
         done   <= (state == DONE) ? (3'b001 << winner) : 3'd0;
         case (state)
            IDLE: if (|req) begin
               winner <= pick;
               cx     <= 4'd0;
               cy     <= 4'd0;
            end
            ERASE, DRAW: begin
               if (cx == w_m1) begin
                  cx <= 4'd0;
                  cy <= (cy == h_m1) ? 4'd0 : cy + 4'd1;
               end else begin
                  cx <= cx + 4'd1;
               end
            end
            default: begin
               old_valid[winner] <= 1'b1;
               rr_ptr            <= winner;
            end
         endcase
      end
   end

   // NOTE: position storage is not reset; old_valid alone says whether it holds a drawn rectangle.
   always_ff @(posedge clock) begin
      if (state == IDLE && |req) begin
         new_x      <= pick_x;
         new_y      <= pick_y;
         w_m1       <= pick_w;
         h_m1       <= pick_h;
         sprite_col <= pick_col;
      end
      if (state == DONE) begin
         old_x[winner] <= new_x;
         old_y[winner] <= new_y;
      end
   end

endmodule

// File: tb/tb_sprite_draw_scheduler.sv
// Directed bench for sprite_draw_scheduler: reset, draw/erase scans, round-robin
// order, clipping, mid-job reset and coordinate latching.
module tb_sprite_draw_scheduler;

   logic       clock = 1'b0;
   logic       reset = 1'b0;
   logic [2:0] req   = 3'd0;
   logic [7:0] x0 = 8'd0, y0 = 8'd0, x1 = 8'd0, y1 = 8'd0, x2 = 8'd0, y2 = 8'd0;
   logic [7:0] vga_x;
   logic [6:0] vga_y;
   logic [2:0] colour;
   logic       plot, busy;
   logic [2:0] done;

   int checks   = 0;
   int failures = 0;

   sprite_draw_scheduler dut (
      .clock(clock), .reset(reset), .req(req),
      .x0(x0), .y0(y0), .x1(x1), .y1(y1), .x2(x2), .y2(y2),
      .vga_x(vga_x), .vga_y(vga_y), .colour(colour),
      .plot(plot), .busy(busy), .done(done)
   );

   always #5 clock = ~clock;

   // Inputs change and outputs are observed 1 time unit after the rising edge.
   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset;
      reset = 1'b0;
      req   = 3'd0;
      tick;
      tick;
      reset = 1'b1;
   endtask

   task automatic test_reset;
      do_reset;
      reset = 1'b0;
      tick;
      checks++;
      if ({plot, busy, done, colour, vga_x, vga_y} !== 23'd0) begin
         failures++;
         $display("FAIL reset_outputs: plot=%b busy=%b done=%b col=%b x=%0d y=%0d, want all 0",
                  plot, busy, done, colour, vga_x, vga_y);
      end
      reset = 1'b1;
      tick;
      checks++;
      if (busy !== 1'b0 || plot !== 1'b0) begin
         failures++;
         $display("FAIL reset_idle: busy=%b plot=%b, want 0 0", busy, plot);
      end
   endtask

   task automatic test_first_draw;
      x0 = 8'd16; y0 = 8'd111; req = 3'b001;
      tick;
      req = 3'b000;
      checks++;
      if (plot !== 1'b0 || busy !== 1'b1) begin
         failures++;
         $display("FAIL first_decision: plot=%b busy=%b, want 0 1", plot, busy);
      end
      for (int i = 0; i < 52; i++) begin
         tick;
         checks++;
         if (plot !== 1'b1 || vga_x !== 8'(16 + i % 13) || vga_y !== 7'(111 + i / 13) || colour !== 3'b010) begin
            failures++;
            $display("FAIL first_px%0d: plot=%b x=%0d y=%0d col=%b, want 1 x=%0d y=%0d col=010",
                     i, plot, vga_x, vga_y, colour, 16 + i % 13, 111 + i / 13);
         end
      end
      tick;
      checks++;
      if (done !== 3'b001 || plot !== 1'b0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL first_done: done=%b plot=%b busy=%b, want 001 0 0", done, plot, busy);
      end
      tick;
      checks++;
      if (done !== 3'b000) begin
         failures++;
         $display("FAIL first_done_pulse: done=%b, want 000", done);
      end
   endtask

   task automatic test_move;
      x0 = 8'd17; req = 3'b001;
      tick;
      req = 3'b000;
      for (int i = 0; i < 104; i++) begin
         int         px;
         logic [2:0] pc;
         px = (i < 52) ? 16 + i % 13 : 17 + (i - 52) % 13;
         pc = (i < 52) ? 3'b000 : 3'b010;
         tick;
         checks++;
         if (plot !== 1'b1 || vga_x !== 8'(px) || vga_y !== 7'(111 + (i % 52) / 13) || colour !== pc || busy !== 1'b1) begin
            failures++;
            $display("FAIL move_px%0d: plot=%b x=%0d y=%0d col=%b busy=%b, want 1 x=%0d y=%0d col=%b busy=1",
                     i, plot, vga_x, vga_y, colour, busy, px, 111 + (i % 52) / 13, pc);
         end
      end
      tick;
      checks++;
      if (done !== 3'b001 || busy !== 1'b0) begin
         failures++;
         $display("FAIL move_done: done=%b busy=%b after 106 cycles, want 001 0", done, busy);
      end
   endtask

   task automatic test_round_robin;
      int order [4];
      int n;
      do_reset;
      x0 = 8'd10; y0 = 8'd10; x1 = 8'd40; y1 = 8'd20; x2 = 8'd80; y2 = 8'd60;
      req = 3'b111;
      n = 0;
      for (int c = 0; c < 400 && n < 4; c++) begin
         tick;
         if (done !== 3'b000) begin
            checks++;
            if (done !== 3'b001 && done !== 3'b010 && done !== 3'b100) begin
               failures++;
               $display("FAIL rr_onehot: done=%b, want exactly one bit", done);
            end
            order[n] = (done == 3'b001) ? 0 : (done == 3'b010) ? 1 : (done == 3'b100) ? 2 : 3;
            n++;
         end
      end
      req = 3'b000;
      checks++;
      if (n !== 4) begin
         failures++;
         $display("FAIL rr_count: %0d done pulses within 400 cycles, want 4", n);
      end
      for (int j = 0; j < n; j++) begin
         checks++;
         if (order[j] !== j % 3) begin
            failures++;
            $display("FAIL rr_order%0d: served %0d, want %0d", j, order[j], j % 3);
         end
      end
   endtask

   task automatic test_clip;
      int plotted;
      do_reset;
      x1 = 8'd156; y1 = 8'd16; req = 3'b010;
      tick;
      req = 3'b000;
      plotted = 0;
      for (int i = 0; i < 48; i++) begin
         tick;
         if (plot === 1'b1) plotted++;
         checks++;
         if (plot !== ((i % 8) < 4) || colour !== 3'b111 || vga_x !== 8'(156 + i % 8) || vga_y !== 7'(16 + i / 8)) begin
            failures++;
            $display("FAIL clip_px%0d: plot=%b col=%b x=%0d y=%0d, want plot=%b col=111 x=%0d y=%0d",
                     i, plot, colour, vga_x, vga_y, (i % 8) < 4, 8'(156 + i % 8), 16 + i / 8);
         end
      end
      checks++;
      if (plotted !== 24) begin
         failures++;
         $display("FAIL clip_count: %0d pixels plotted, want 24", plotted);
      end
      tick;
      checks++;
      if (done !== 3'b010) begin
         failures++;
         $display("FAIL clip_done: done=%b after 48 draw cycles, want 010", done);
      end
   endtask

   task automatic test_reset_mid;
      x1 = 8'd20; y1 = 8'd30; req = 3'b010;
      tick;
      req = 3'b000;
      tick;
      checks++;
      if (colour !== 3'b000 || vga_x !== 8'd156 || vga_y !== 7'd16 || plot !== 1'b1) begin
         failures++;
         $display("FAIL mid_erase_first: col=%b x=%0d y=%0d plot=%b, want 000 156 16 1",
                  colour, vga_x, vga_y, plot);
      end
      for (int i = 0; i < 52; i++) tick;
      checks++;
      if (colour !== 3'b111 || busy !== 1'b1) begin
         failures++;
         $display("FAIL mid_in_draw: col=%b busy=%b, want 111 1", colour, busy);
      end
      reset = 1'b0;
      tick;
      reset = 1'b1;
      checks++;
      if (plot !== 1'b0 || busy !== 1'b0 || done !== 3'b000) begin
         failures++;
         $display("FAIL mid_abort: plot=%b busy=%b done=%b, want 0 0 000", plot, busy, done);
      end
      req = 3'b010;
      tick;
      req = 3'b000;
      tick;
      checks++;
      if (colour !== 3'b111 || plot !== 1'b1 || vga_x !== 8'd20 || vga_y !== 7'd30) begin
         failures++;
         $display("FAIL mid_no_erase: col=%b plot=%b x=%0d y=%0d, want 111 1 20 30",
                  colour, plot, vga_x, vga_y);
      end
      for (int i = 0; i < 47; i++) tick;
      tick;
      checks++;
      if (done !== 3'b010) begin
         failures++;
         $display("FAIL mid_redraw_done: done=%b, want 010", done);
      end
   endtask

   task automatic test_shot_latch;
      int pulses;
      x2 = 8'd50; y2 = 8'd40; req = 3'b100;
      tick;
      x2 = 8'd90; y2 = 8'd90; req = 3'b000;
      for (int i = 0; i < 3; i++) begin
         tick;
         checks++;
         if (plot !== 1'b1 || vga_x !== 8'd50 || vga_y !== 7'(40 + i) || colour !== 3'b110) begin
            failures++;
            $display("FAIL shot_px%0d: plot=%b x=%0d y=%0d col=%b, want 1 50 %0d 110",
                     i, plot, vga_x, vga_y, colour, 40 + i);
         end
      end
      tick;
      checks++;
      if (done !== 3'b100) begin
         failures++;
         $display("FAIL shot_done: done=%b, want 100", done);
      end
      pulses = 0;
      for (int i = 0; i < 6; i++) begin
         tick;
         if (done !== 3'b000) pulses++;
      end
      checks++;
      if (pulses !== 0 || busy !== 1'b0) begin
         failures++;
         $display("FAIL shot_once: %0d extra done pulses busy=%b, want 0 0", pulses, busy);
      end
   endtask

   initial begin
      test_reset;
      test_first_draw;
      test_move;
      test_round_robin;
      test_clip;
      test_reset_mid;
      test_shot_latch;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
